// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage: sequential fetch, branch, jump,
// register jump, stall, and a circular return-address stack for call/return.
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           pc_src,
    input  logic [WIDTH-1:0]               sign_imm,
    input  logic                           jump,
    input  logic [WIDTH-1:0]               jump_target,
    input  logic                           jr,
    input  logic [WIDTH-1:0]               jr_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               pc_plus4,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_err
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             push_s, pop_s, empty_s, full_s;
    logic [WIDTH-1:0] pc_plus4_s, branch_tgt_s, tos_s;
    logic             unused_s;

    assign pc_plus4_s   = pc_q + WIDTH'(4);
    assign branch_tgt_s = pc_plus4_s + {sign_imm[WIDTH-3:0], 2'b00};
    // top_q points at the next free slot, so the newest entry sits one below it
    assign tos_s        = ras_q[top_q - PW'(1)];
    assign empty_s      = (cnt_q == {CW{1'b0}});
    assign full_s       = (cnt_q == DEPTH_C);
    assign push_s       = call && (jump || jr) && !stall && !ret;
    assign pop_s        = ret && !stall;
    assign unused_s     = ^{jump_target[1:0], jr_target[1:0], sign_imm[WIDTH-1:WIDTH-2]};

    // Next-PC selection in priority order
    always_comb begin
        pc_d = pc_plus4_s;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            pc_d = empty_s ? pc_plus4_s : tos_s;
        end else if (jr) begin
            pc_d = {jr_target[WIDTH-1:2], 2'b00};
        end else if (jump) begin
            pc_d = {jump_target[WIDTH-1:2], 2'b00};
        end else if (pc_src) begin
            pc_d = branch_tgt_s;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // RAS pointer/count update; a full push overwrites the oldest slot in place
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (pop_s) begin
            if (empty_s) begin
                err_d = 1'b1;
            end else begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end else if (push_s) begin
            top_d = top_q + PW'(1);
            if (full_s) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            top_d = top_q;
            cnt_d = cnt_q;
        end
    end

    // Control-state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            top_q <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Return-address storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            ras_q[top_q] <= pc_plus4_s;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_s;
    assign ras_count = cnt_q;
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, fetch, branches, priority, nested calls,
// RAS overflow/underflow and asynchronous reset mid-operation.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall, pc_src, jump, jr, call, ret;
    logic [31:0] sign_imm, jump_target, jr_target;
    logic [31:0] pc, pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_err;

    int tests_run = 0;
    int tests_failed = 0;

    pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
        .sign_imm(sign_imm), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target), .call(call), .ret(ret),
        .pc(pc), .pc_plus4(pc_plus4), .ras_count(ras_count), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_cnt, input logic [31:0] e_err);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".cnt"}, {29'd0, ras_count}, e_cnt);
        chk({tag, ".err"}, {31'd0, ras_err}, e_err);
    endtask

    task automatic clear();
        stall = 1'b0; pc_src = 1'b0; jump = 1'b0; jr = 1'b0; call = 1'b0; ret = 1'b0;
        sign_imm = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [31:0] tgt, input logic c);
        jump = 1'b1; jump_target = tgt; call = c;
        tick();
        clear();
    endtask

    task automatic do_ret();
        ret = 1'b1;
        tick();
        clear();
    endtask

    initial begin
        clear();
        reset = 1'b0;
        #2;
        chk_state("reset", 32'h0, 32'd0, 32'd0);
        #10;
        reset = 1'b1;
        chk("rel.pc", pc, 32'h0);
        chk("rel.pc4", pc_plus4, 32'h4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq.pc", pc, 32'(i * 4));
            chk("seq.pc4", pc_plus4, 32'(i * 4 + 4));
        end

        // Backward branch with wrap from 0x10
        pc_src = 1'b1; sign_imm = 32'hFFFF_FFFA;
        tick(); clear();
        chk("br_wrap.pc", pc, 32'hFFFF_FFFC);
        chk("br_wrap.pc4", pc_plus4, 32'h0);
        do_jump(32'h0000_0103, 1'b0);
        chk("jump_lowbits", pc, 32'h100);
        pc_src = 1'b1; sign_imm = 32'd50;
        tick(); clear();
        chk("br_fwd", pc, 32'h1CC);

        // Priority: prepare RAS holding 0x200 with pc 0x40
        do_jump(32'h1FC, 1'b0);
        do_jump(32'h40, 1'b1);
        chk_state("prio_setup", 32'h40, 32'd1, 32'd0);
        stall = 1'b1; ret = 1'b1; jr = 1'b1; jr_target = 32'h300;
        jump = 1'b1; jump_target = 32'h400; pc_src = 1'b1; call = 1'b1;
        tick(); clear();
        chk_state("prio_stall", 32'h40, 32'd1, 32'd0);
        ret = 1'b1; jr = 1'b1; jr_target = 32'h300;
        jump = 1'b1; jump_target = 32'h400; pc_src = 1'b1;
        tick(); clear();
        chk_state("prio_ret", 32'h200, 32'd0, 32'd0);

        // Nested call/return
        do_jump(32'h10, 1'b0);
        do_jump(32'h80, 1'b1);
        chk_state("call1", 32'h80, 32'd1, 32'd0);
        do_jump(32'hC0, 1'b1);
        chk_state("call2", 32'hC0, 32'd2, 32'd0);
        do_jump(32'h500, 1'b1);
        chk_state("call3", 32'h500, 32'd3, 32'd0);
        do_ret();
        chk_state("ret1", 32'hC4, 32'd2, 32'd0);
        do_ret();
        chk_state("ret2", 32'h84, 32'd1, 32'd0);
        do_ret();
        chk_state("ret3", 32'h14, 32'd0, 32'd0);
        call = 1'b1;
        tick(); clear();
        chk_state("call_alone", 32'h18, 32'd0, 32'd0);

        // Overflow: five calls into a four-deep stack
        do_jump(32'h1000, 1'b1);
        do_jump(32'h2000, 1'b1);
        do_jump(32'h3000, 1'b1);
        do_jump(32'h4000, 1'b1);
        chk_state("ovf_call4", 32'h4000, 32'd4, 32'd0);
        do_jump(32'h5000, 1'b1);
        chk_state("ovf_call5", 32'h5000, 32'd4, 32'd1);
        tick();
        chk_state("ovf_after", 32'h5004, 32'd4, 32'd0);
        do_ret();
        chk_state("ovf_ret1", 32'h4004, 32'd3, 32'd0);
        do_ret();
        chk_state("ovf_ret2", 32'h3004, 32'd2, 32'd0);
        do_ret();
        chk_state("ovf_ret3", 32'h2004, 32'd1, 32'd0);
        do_ret();
        chk_state("ovf_ret4", 32'h1004, 32'd0, 32'd0);
        do_ret();
        chk_state("udf_ret", 32'h1008, 32'd0, 32'd1);
        tick();
        chk_state("udf_after", 32'h100C, 32'd0, 32'd0);

        // Reset mid-operation with two entries on the stack
        do_jump(32'h7C, 1'b0);
        do_jump(32'h80, 1'b1);
        jr = 1'b1; jr_target = 32'h85; call = 1'b1;
        tick(); clear();
        chk_state("mid_setup", 32'h84, 32'd2, 32'd0);
        #3;
        reset = 1'b0;
        #1;
        chk_state("mid_reset", 32'h0, 32'd0, 32'd0);
        #2;
        reset = 1'b1;
        do_ret();
        chk_state("post_reset_ret", 32'h4, 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage, replacing the fixed-width increment/branch counter. It supports sequential fetch, PC-relative branches, absolute jumps, register jumps, and a fetch stall. A small return-address stack (RAS) pushes on calls and pops on returns. It drives the program-memory address and supplies `pc_plus4` to the datapath.

## Interface
- `WIDTH`, 32, PC/address width in bits (≥ 8)
- `RESET_VECTOR`, 0, PC value loaded on reset (word-aligned)
- `RAS_DEPTH`, 4, return-address stack entries (≥ 2, power of two)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold PC and RAS unchanged this cycle
- `pc_src`  in  1  branch taken: PC-relative redirect
- `sign_imm`  in  WIDTH  signed word offset for branch (two's complement)
- `jump`  in  1  absolute jump
- `jump_target`  in  WIDTH  absolute jump address; bits [1:0] ignored
- `jr`  in  1  register jump
- `jr_target`  in  WIDTH  register jump address; bits [1:0] ignored
- `call`  in  1  push `pc_plus4` onto RAS (qualifies `jump` or `jr`)
- `ret`  in  1  return: pop RAS and redirect to popped address
- `pc`  out  WIDTH  current fetch address
- `pc_plus4`  out  WIDTH  combinational `pc + 4`, modulo 2^WIDTH
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- `ras_err`  out  1  one-cycle pulse: RAS overflow or underflow event

## Operation
- Next-PC priority: `stall` > `ret` > `jr` > `jump` > `pc_src` > sequential.
  - sequential: `pc + 4`
  - branch: `pc + 4 + (sign_imm << 2)`
  - jump: `{jump_target[WIDTH-1:2], 2'b00}`
  - jr: `{jr_target[WIDTH-1:2], 2'b00}`
  - ret: top-of-stack entry
- All arithmetic is WIDTH bits and wraps modulo 2^WIDTH. No overflow detection.
- RAS is a circular buffer with a top pointer and a saturating count.
- Push occurs when `call && (jump || jr) && !stall && !ret`. The pushed value is `pc_plus4` of the current cycle.
  - `call` without `jump`/`jr` is ignored.
- Pop occurs when `ret && !stall`.
- Full push (count == `RAS_DEPTH`): the oldest entry is overwritten, count stays at `RAS_DEPTH`, and `ras_err` pulses.
- Empty pop (count == 0): PC takes `pc + 4`, count stays 0, and `ras_err` pulses.
- `ret` together with `call`: pop only, no push.
- `stall` freezes `pc`, the RAS, and `ras_count`, and forces `ras_err` low. All other inputs are ignored.

## Timing
- Reset asserted (`reset` = 0), taking effect immediately and asynchronously:
  - `pc` = `RESET_VECTOR`
  - `ras_count` = 0
  - `ras_err` = 0
  - RAS pointer = 0 (entry contents are don't-care)
- First update: the first rising edge after `reset` deasserts.
- Redirect latency is 1 cycle: control sampled at edge N sets `pc` after edge N.
- `pc_plus4` is combinational from `pc`, with zero latency.
- `ras_count` and `ras_err` are registered and update on the same edge as `pc`.
- `ras_err` is high for exactly the one cycle following the offending edge.
- Reset asserted mid-operation aborts any pending push/pop. No partial RAS state is retained in the count.
- Registered outputs are driven solely from flops.

## Test plan
- **Reset and sequential fetch.** Use WIDTH=32 and RESET_VECTOR=0. Hold `reset`=0 for 10 ns, then release with no controls asserted. Required: `pc` reads 0, 4, 8, … on successive edges, and `pc_plus4` = `pc` + 4 every cycle.
- **Backward branch with wrap.** At `pc`=0x10, apply `pc_src`=1 with `sign_imm`=−6. Required: next `pc`=0xFFFFFFFC. Then, at `pc`=0x100, apply `sign_imm`=50. Required: next `pc`=0x1CC.
- **Control priority.** At `pc`=0x40, assert `ret` (RAS holds 0x200), `jr` (0x300), `jump` (0x400), and `pc_src` all in one cycle. Required: `pc`=0x200. Repeat with `stall`=1 as well. Required: `pc` holds at 0x40 and `ras_count` is unchanged.
- **Nested call/return.** Perform three calls via `jump`+`call` from 0x10, 0x80, and 0xC0, then three `ret`s. Required: `ras_count` reads 1, 2, 3, then 2, 1, 0. The returns land at 0xC4, 0x84, and 0x14.
- **Overflow and underflow.** Use RAS_DEPTH=4. Issue 5 calls. Required: `ras_err` pulses once on the 5th, `ras_count`=4, and 4 returns yield the 5th, 4th, 3rd, and 2nd return addresses. Then issue one more `ret`. Required: `ras_err` pulses and `pc` = previous `pc` + 4.
- **Reset mid-operation.** With `ras_count`=2 and `pc`=0x84, drive `reset`=0 between clock edges. Required: `pc`=0 and `ras_count`=0 before the next edge. After release, a `ret` raises `ras_err`.
